// File: rtl/sqrt_pkg.sv
// Shared definitions for the Newton-iteration square root sequencer:
// FSM encoding, default sizing and the starting-guess rule.
package sqrt_pkg;

  localparam int DEF_WIDTH    = 20;
  localparam int DEF_MAX_ITER = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    DIV,
    UPDATE,
    CHECK,
    DONE
  } sqrt_state_t;

  // 2^ceil(width/2) is never below sqrt of any width-bit operand, so
  // Newton descends monotonically from it.
  function automatic longint unsigned seed_value(input int unsigned width);
    return 64'd1 << ((width + 1) / 2);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock. The first bit is resolved
// on the start edge, so valid pulses WIDTH cycles after start.
module seq_divider #(
  parameter int WIDTH = 20
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, den;
  logic [WIDTH-1:0] rem_in, quo_in, den_in, rem_nxt, quo_nxt;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [CW-1:0]    cnt;
  logic             run;

  always_comb begin
    rem_in  = start ? '0 : rem;
    quo_in  = start ? dividend : quo;
    den_in  = start ? divisor : den;
    trial   = {rem_in, quo_in[WIDTH-1]};
    take    = trial >= {1'b0, den_in};
    rem_nxt = take ? WIDTH'(trial - {1'b0, den_in}) : trial[WIDTH-1:0];
    quo_nxt = {quo_in[WIDTH-2:0], take};
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rem   <= '0;
      quo   <= '0;
      den   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        den <= divisor;
        cnt <= CW'(1);
        run <= 1'b1;
      end else if (run) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          run   <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/sqrt_sequencer.sv
// Integer square root by Newton iteration x' = (x + N/x)/2 from a
// power-of-two seed, with a shared sequential divider per step.
module sqrt_sequencer
  import sqrt_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [3:0]         iter_count,
  output logic               timeout
);

  localparam int KW = $clog2(MAX_ITER + 1);
  localparam logic [WIDTH-1:0] SEED_X = WIDTH'(seed_value(WIDTH));

  sqrt_state_t state, state_n;

  logic [WIDTH-1:0] n, x, q;
  logic [WIDTH:0]   y;
  logic [WIDTH+1:0] sum;
  logic [KW-1:0]    k;
  logic             conv, cap;
  logic             div_start, div_valid;
  logic [WIDTH-1:0] div_den, div_q;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (div_start),
    .dividend (n),
    .divisor  (div_den),
    .valid    (div_valid),
    .quotient (div_q)
  );

  // Sum kept two bits wider so the halving never loses a carry.
  always_comb begin
    sum       = {2'b00, x} + {2'b00, q};
    conv      = y >= {1'b0, x};
    cap       = (k == KW'(MAX_ITER));
    state_n   = state;
    div_start = 1'b0;
    div_den   = x;
    case (state)
      IDLE:   if (start) state_n = SEED;
      SEED: begin
        if (n == '0) begin
          state_n = DONE;
        end else begin
          div_start = 1'b1;
          div_den   = SEED_X;
          state_n   = DIV;
        end
      end
      DIV:    if (div_valid) state_n = UPDATE;
      UPDATE: state_n = CHECK;
      CHECK: begin
        if (conv || cap) begin
          state_n = DONE;
        end else begin
          div_start = 1'b1;
          div_den   = y[WIDTH-1:0];
          state_n   = DIV;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      n          <= '0;
      x          <= '0;
      q          <= '0;
      y          <= '0;
      k          <= '0;
      root       <= '0;
      iter_count <= '0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n       <= operand;
            timeout <= 1'b0;
          end
        end
        SEED: begin
          x <= SEED_X;
          k <= '0;
          if (n == '0) begin
            root       <= '0;
            iter_count <= '0;
          end
        end
        DIV:    if (div_valid) q <= div_q;
        UPDATE: begin
          y <= (WIDTH+1)'(sum >> 1);
          k <= k + KW'(1);
        end
        CHECK: begin
          if (conv) begin
            root       <= x[WIDTH/2-1:0];
            iter_count <= 4'(k);
          end else begin
            x <= y[WIDTH-1:0];
            if (cap) begin
              timeout    <= 1'b1;
              root       <= y[WIDTH/2-1:0];
              iter_count <= 4'(k);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Scoreboard bench for sqrt_sequencer: the driver queues expected results from
// a plain-arithmetic model, the monitor checks each done pulse against them.
module tb_sqrt_sequencer;

  localparam int W   = 20;
  localparam int PER = W + 2;

  logic           CLOCK_50 = 1'b0;
  logic           reset;
  logic           start = 1'b0;
  logic [W-1:0]   operand = '0;
  logic           busy, done, timeout;
  logic [W/2-1:0] root;
  logic [3:0]     iter_count;

  sqrt_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .root       (root),
    .iter_count (iter_count),
    .timeout    (timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    longint n;
    longint r;
    longint k;
    longint s;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  logic   prev_done = 1'b0;

  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint ref_isqrt(input longint n);
    longint r;
    r = longint'($sqrt(real'(n)));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Newton step count from seed 2^ceil(W/2), stopping when the guess stops falling.
  function automatic longint ref_steps(input longint n);
    longint x, y;
    if (n == 0) return 0;
    x = longint'(1) << ((W + 1) / 2);
    for (int s = 1; s <= 16; s++) begin
      y = (x + n / x) / 2;
      if (y >= x) return s;
      x = y;
    end
    return 16;
  endfunction

  // Monitor: busy across every in-flight op, and full result check on done.
  always @(negedge CLOCK_50) begin
    if (reset) begin
      if (sb.size() > 0 && cyc > sb[0].s) chk("busy_in_flight", longint'(busy), 1);
      if (done) begin
        chk("done_while_busy", longint'(busy), 1);
        chk("done_single_cycle", longint'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("root", longint'(root), e.r);
          chk("iter_count", longint'(iter_count), e.k);
          chk("timeout", longint'(timeout), 0);
          chk("latency", cyc - e.s + 1, 3 + e.k * PER);
          chk("root_bounds",
              (longint'(root) * longint'(root) <= e.n &&
               e.n < (longint'(root) + 1) * (longint'(root) + 1)) ? 1 : 0, 1);
        end
      end
    end
    prev_done = done;
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic issue(input longint n);
    exp_t x;
    x.n = n;
    x.r = ref_isqrt(n);
    x.k = ref_steps(n);
    x.s = cyc;
    sb.push_back(x);
    start   = 1'b1;
    operand = W'(n);
    @(negedge CLOCK_50);
    start   = 1'b0;
    operand = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK_50);
      if (sb.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: no completion within 2000 cycles, pending=%0d", sb.size());
    sb.delete();
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint dir[5] = '{0, 144, 999999, 1048575, 1};
    longint nv;

    reset = 1'b1;
    #2 reset = 1'b0;
    #3;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_root", longint'(root), 0);
    chk("rst_iter", longint'(iter_count), 0);
    chk("rst_timeout", longint'(timeout), 0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;

    foreach (dir[i]) begin
      issue(dir[i]);
      wait_idle();
    end

    // Spurious start pulses with a different operand while computing 144.
    issue(144);
    repeat (3) @(negedge CLOCK_50);
    start = 1'b1; operand = 4;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    start = 1'b1; operand = 4;
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge CLOCK_50);
    chk("root_hold", longint'(root), 12);

    // Abort in the middle of the first divide, then restart straight away.
    issue(999999);
    repeat (5) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_root", longint'(root), 0);
    chk("abort_iter", longint'(iter_count), 0);
    chk("abort_timeout", longint'(timeout), 0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    issue(81);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0:       nv = longint'($urandom_range(0, 300));
        1:       nv = longint'($urandom_range(1040000, 1048575));
        default: nv = longint'($urandom_range(0, 1048575));
      endcase
      issue(nv);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
